// File: rtl/multicycle_control_unit_if.sv
// Control-unit bus: run/opcode/mem_ready in, all datapath control strobes out.
// master = control unit, slave = datapath or environment driving it.
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2
);
  logic                run;
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                pc_write;
  logic                pc_write_cond;
  logic [1:0]          pc_src;
  logic                ir_write;
  logic                iord;
  logic                mem_read;
  logic                mem_write;
  logic                mem_to_reg;
  logic                reg_dst;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [ALUOP_W-1:0]  alu_op;
  logic                instr_done;
  logic                illegal_op;
  logic                timeout_err;
  logic [2:0]          state_o;

  modport master (
    input  run, opcode, mem_ready,
    output pc_write, pc_write_cond, pc_src, ir_write, iord, mem_read, mem_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           instr_done, illegal_op, timeout_err, state_o
  );

  modport slave (
    output run, opcode, mem_ready,
    input  pc_write, pc_write_cond, pc_src, ir_write, iord, mem_read, mem_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           instr_done, illegal_op, timeout_err, state_o
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer; one state per cycle, FETCH/MEM hold until mem_ready.
// Define MEM_TIMEOUT_EN to trap once a FETCH/MEM stall lasts TIMEOUT_CYCLES cycles.
module multicycle_control_unit #(
  parameter int OPCODE_W       = 6,
  parameter int ALUOP_W        = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                       clk,
  input logic                       rst_n,
  multicycle_control_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_BRJ    = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_IMM, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_ILLEGAL
  } op_class_t;

  // Range compares on the full width, so any nonzero upper bit lands in C_ILLEGAL.
  function automatic op_class_t classify(input logic [OPCODE_W-1:0] op);
    op_class_t c;
    if (op == '0)                                          c = C_R;
    else if (op >= OPCODE_W'(8)  && op <= OPCODE_W'(14))   c = C_IMM;
    else if (op >= OPCODE_W'(32) && op <= OPCODE_W'(38))   c = C_LOAD;
    else if (op >= OPCODE_W'(40) && op <= OPCODE_W'(46))   c = C_STORE;
    else if (op >= OPCODE_W'(4)  && op <= OPCODE_W'(7))    c = C_BRANCH;
    else if (op >= OPCODE_W'(1)  && op <= OPCODE_W'(2))    c = C_JUMP;
    else                                                   c = C_ILLEGAL;
    return c;
  endfunction

  state_t              state, state_nx;
  logic [OPCODE_W-1:0] op_q;
  logic                illegal_q, timeout_q;
  logic                stall_to;
  op_class_t           cls, dec_cls;

  assign cls     = classify(op_q);
  assign dec_cls = classify(bus.opcode);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] stall_cnt;
  logic             stalled;

  assign stalled  = ((state == S_FETCH) || (state == S_MEM)) && !bus.mem_ready;
  assign stall_to = stalled && (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       stall_cnt <= '0;
    else if (stalled) stall_cnt <= stall_cnt + 1'b1;
    else              stall_cnt <= '0;
  end
`else
  assign stall_to = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_DECODE) op_q <= bus.opcode;
      if (state == S_DECODE && dec_cls == C_ILLEGAL) illegal_q <= 1'b1;
      if (stall_to) timeout_q <= 1'b1;
    end
  end

  always_comb begin
    state_nx          = state;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_src        = 2'd0;
    bus.ir_write      = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'd0;
    bus.alu_op        = '0;
    bus.instr_done    = 1'b0;
    case (state)
      S_IDLE: if (bus.run) state_nx = S_FETCH;
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'd1;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_nx     = S_DECODE;
        end else if (stall_to) begin
          state_nx = S_TRAP;
        end
      end
      S_DECODE: begin
        bus.alu_src_b = 2'd3;
        case (dec_cls)
          C_BRANCH, C_JUMP: state_nx = S_BRJ;
          C_ILLEGAL:        state_nx = S_TRAP;
          default:          state_nx = S_EXEC;
        endcase
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        case (cls)
          C_R: begin
            bus.alu_op = ALUOP_W'(2);
            state_nx   = S_WB;
          end
          C_IMM: begin
            bus.alu_src_b = 2'd2;
            bus.alu_op    = ALUOP_W'(3);
            state_nx      = S_WB;
          end
          default: begin
            bus.alu_src_b = 2'd2;
            state_nx      = S_MEM;
          end
        endcase
      end
      S_MEM: begin
        bus.iord      = 1'b1;
        bus.mem_read  = (cls == C_LOAD);
        bus.mem_write = (cls == C_STORE);
        if (bus.mem_ready) begin
          if (cls == C_LOAD) begin
            state_nx = S_WB;
          end else begin
            bus.instr_done = 1'b1;
            state_nx       = bus.run ? S_FETCH : S_IDLE;
          end
        end else if (stall_to) begin
          state_nx = S_TRAP;
        end
      end
      S_WB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = (cls == C_R);
        bus.mem_to_reg = (cls == C_LOAD);
        bus.instr_done = 1'b1;
        state_nx       = bus.run ? S_FETCH : S_IDLE;
      end
      S_BRJ: begin
        if (cls == C_BRANCH) begin
          bus.alu_src_a     = 1'b1;
          bus.alu_op        = ALUOP_W'(1);
          bus.pc_write_cond = 1'b1;
          bus.pc_src        = 2'd1;
        end else begin
          bus.pc_write = 1'b1;
          bus.pc_src   = 2'd2;
        end
        bus.instr_done = 1'b1;
        state_nx       = bus.run ? S_FETCH : S_IDLE;
      end
      default: state_nx = S_TRAP;
    endcase
  end

  assign bus.illegal_op  = illegal_q;
  assign bus.timeout_err = timeout_q;
  assign bus.state_o     = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: an instruction-level model schedules the expected per-cycle outputs,
// a negedge process compares them against the control unit.
module tb_multicycle_control_unit;

  localparam int K_R = 0, K_IMM = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4, K_J = 5, K_ILL = 6, K_TO = 7;

  typedef struct packed {
    logic [2:0] st;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
    logic       timeout_err;
  } obs_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  obs_t exp_obs;
  logic exp_vld;
  int   ilen = 0;
  int   last_len = 0;

  multicycle_control_unit_if #(.OPCODE_W(6), .ALUOP_W(2)) bus ();

  multicycle_control_unit #(.OPCODE_W(6), .ALUOP_W(2), .TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.st            = bus.state_o;
    o.pc_write      = bus.pc_write;
    o.pc_write_cond = bus.pc_write_cond;
    o.pc_src        = bus.pc_src;
    o.ir_write      = bus.ir_write;
    o.iord          = bus.iord;
    o.mem_read      = bus.mem_read;
    o.mem_write     = bus.mem_write;
    o.mem_to_reg    = bus.mem_to_reg;
    o.reg_dst       = bus.reg_dst;
    o.reg_write     = bus.reg_write;
    o.alu_src_a     = bus.alu_src_a;
    o.alu_src_b     = bus.alu_src_b;
    o.alu_op        = bus.alu_op;
    o.instr_done    = bus.instr_done;
    o.illegal_op    = bus.illegal_op;
    o.timeout_err   = bus.timeout_err;
    return o;
  endfunction

  function automatic int class_of(input int op);
    if (op == 0)              return K_R;
    if (op >= 8 && op <= 14)  return K_IMM;
    if (op >= 32 && op <= 38) return K_LOAD;
    if (op >= 40 && op <= 46) return K_STORE;
    if (op >= 4 && op <= 7)   return K_BR;
    if (op >= 1 && op <= 2)   return K_J;
    return K_ILL;
  endfunction

  // Expected outputs for one cycle spent in phase ph by an instruction of class cls.
  function automatic obs_t expect_obs(input int ph, input int cls, input logic rdy);
    obs_t o;
    o    = '0;
    o.st = 3'(ph);
    case (ph)
      1: begin
        o.mem_read  = 1'b1;
        o.alu_src_b = 2'd1;
        o.ir_write  = rdy;
        o.pc_write  = rdy;
      end
      2: o.alu_src_b = 2'd3;
      3: begin
        o.alu_src_a = 1'b1;
        if (cls == K_R) o.alu_op = 2'd2;
        else begin
          o.alu_src_b = 2'd2;
          o.alu_op    = (cls == K_IMM) ? 2'd3 : 2'd0;
        end
      end
      4: begin
        o.iord       = 1'b1;
        o.mem_read   = (cls == K_LOAD);
        o.mem_write  = (cls == K_STORE);
        o.instr_done = (cls == K_STORE) && rdy;
      end
      5: begin
        o.reg_write  = 1'b1;
        o.reg_dst    = (cls == K_R);
        o.mem_to_reg = (cls == K_LOAD);
        o.instr_done = 1'b1;
      end
      6: begin
        if (cls == K_BR) begin
          o.alu_src_a     = 1'b1;
          o.alu_op        = 2'd1;
          o.pc_write_cond = 1'b1;
          o.pc_src        = 2'd1;
        end else begin
          o.pc_write = 1'b1;
          o.pc_src   = 2'd2;
        end
        o.instr_done = 1'b1;
      end
      7: begin
        o.illegal_op  = (cls == K_ILL);
        o.timeout_err = (cls == K_TO);
      end
      default: ;
    endcase
    return o;
  endfunction

  task automatic step(input int ph, input int cls, input logic rdy, input logic rv);
    bus.run       = rv;
    bus.mem_ready = rdy;
    exp_obs       = expect_obs(ph, cls, rdy);
    exp_vld       = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Schedules one whole instruction from its first FETCH cycle onward.
  task automatic do_instr(input int op, input int fw, input int mw, input logic rv);
    int cls;
    cls        = class_of(op);
    bus.opcode = 6'(op);
    for (int i = 0; i < fw; i++) step(1, cls, 1'b0, rv);
    step(1, cls, 1'b1, rv);
    step(2, cls, 1'b1, rv);
    if (cls == K_ILL) return;
    if (cls == K_BR || cls == K_J) begin
      step(6, cls, 1'b0, rv);
    end else begin
      step(3, cls, 1'b0, rv);
      if (cls == K_LOAD || cls == K_STORE) begin
        for (int i = 0; i < mw; i++) step(4, cls, 1'b0, rv);
        step(4, cls, 1'b1, rv);
      end
      if (cls != K_STORE) step(5, cls, 1'b1, rv);
    end
  endtask

  task automatic do_reset();
    exp_vld = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_state", 32'(bus.state_o), 32'd0);
    chk("reset_outs", 32'(sample()), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    obs_t a;
    a = sample();
    if (exp_vld) begin
      chk("cycle_obs", 32'(a), 32'(exp_obs));
      chk("mem_rw_excl", 32'(a.mem_read & a.mem_write), 32'd0);
    end
    if (!rst_n || a.st == 3'd0 || a.st == 3'd7) ilen = 0;
    else begin
      ilen++;
      if (a.instr_done) begin
        last_len = ilen;
        ilen     = 0;
      end
    end
  end

  initial begin
    obs_t m;
    int   ill_ops [4];
    ill_ops       = '{15, 39, 47, 63};
    rst_n         = 1'b0;
    exp_vld       = 1'b0;
    bus.run       = 1'b0;
    bus.opcode    = '0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(bus.state_o), 32'd0);
    chk("reset_outs", 32'(sample()), 32'd0);
    rst_n = 1'b1;

    // Pin the model with hand-derived output groups.
    m = expect_obs(5, K_R, 1'b0);
    chk("pin_wb_r", {m.reg_write, m.reg_dst, m.mem_to_reg, m.instr_done}, 32'b1101);
    m = expect_obs(5, K_LOAD, 1'b0);
    chk("pin_wb_load", {m.reg_write, m.reg_dst, m.mem_to_reg, m.instr_done}, 32'b1011);
    m = expect_obs(4, K_STORE, 1'b1);
    chk("pin_mem_store", {m.mem_write, m.mem_read, m.instr_done, m.iord}, 32'b1011);
    m = expect_obs(6, K_BR, 1'b0);
    chk("pin_brj_branch", {m.pc_write_cond, m.pc_src, m.alu_op, m.pc_write}, 32'b1_01_01_0);
    m = expect_obs(6, K_J, 1'b0);
    chk("pin_brj_jump", {m.pc_write_cond, m.pc_src, m.alu_op, m.pc_write}, 32'b0_10_00_1);

    step(0, K_R, 1'b0, 1'b1);
    do_instr(0, 0, 0, 1'b1);   chk("len_r0", last_len, 4);
    do_instr(0, 0, 0, 1'b1);   chk("len_r1", last_len, 4);
    do_instr(8, 0, 0, 1'b1);   chk("len_imm", last_len, 4);
    do_instr(35, 0, 3, 1'b1);  chk("len_load_wait3", last_len, 8);
    do_instr(32, 0, 0, 1'b1);  chk("len_load", last_len, 5);
    do_instr(43, 0, 0, 1'b1);  chk("len_store", last_len, 4);
    do_instr(4, 0, 0, 1'b1);   chk("len_branch", last_len, 3);
    do_instr(2, 0, 0, 1'b1);   chk("len_jump", last_len, 3);
    do_instr(14, 3, 0, 1'b1);  chk("len_imm_fetch_wait3", last_len, 7);
    do_instr(46, 1, 2, 1'b0);  chk("len_store_waits", last_len, 7);
    step(0, K_R, 1'b1, 1'b0);
    step(0, K_R, 1'b0, 1'b0);

    // run drops inside an instruction: it still completes before IDLE.
    step(0, K_R, 1'b0, 1'b1);
    do_instr(38, 0, 0, 1'b0);  chk("len_load_run_low", last_len, 5);
    step(0, K_R, 1'b0, 1'b0);
    step(0, K_R, 1'b0, 1'b1);
    do_instr(7, 0, 0, 1'b1);   chk("len_branch7", last_len, 3);
    do_instr(1, 0, 0, 1'b0);   chk("len_jump1", last_len, 3);
    step(0, K_R, 1'b0, 1'b0);

    step(0, K_R, 1'b0, 1'b1);
    do_instr(3, 0, 0, 1'b1);
    for (int i = 0; i < 20; i++) step(7, K_ILL, 1'(i % 2), 1'(i % 3 == 0));
    chk("trap_illegal_op", 32'(bus.illegal_op), 32'd1);
    chk("trap_timeout_err", 32'(bus.timeout_err), 32'd0);
    do_reset();

    foreach (ill_ops[k]) begin
      step(0, K_R, 1'b0, 1'b1);
      do_instr(ill_ops[k], 0, 0, 1'b1);
      step(7, K_ILL, 1'b1, 1'b1);
      step(7, K_ILL, 1'b0, 1'b0);
      do_reset();
    end

`ifdef MEM_TIMEOUT_EN
    step(0, K_R, 1'b0, 1'b1);
    bus.opcode = '0;
    for (int i = 0; i < 4; i++) step(1, K_R, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(7, K_TO, 1'(i % 2), 1'b1);
    chk("timeout_err_set", 32'(bus.timeout_err), 32'd1);
    chk("timeout_no_illegal", 32'(bus.illegal_op), 32'd0);
    do_reset();
`endif

    // Reset asserted while a load is stalled in MEM.
    step(0, K_R, 1'b0, 1'b1);
    bus.opcode = 6'd35;
    step(1, K_LOAD, 1'b1, 1'b1);
    step(2, K_LOAD, 1'b0, 1'b1);
    step(3, K_LOAD, 1'b0, 1'b1);
    step(4, K_LOAD, 1'b0, 1'b1);
    step(4, K_LOAD, 1'b0, 1'b1);
    chk("pre_reset_in_mem", 32'(bus.state_o), 32'd4);
    do_reset();

    step(0, K_R, 1'b0, 1'b1);
    do_instr(0, 0, 0, 1'b0);   chk("len_r_after_reset", last_len, 4);
    step(0, K_R, 1'b0, 1'b0);
    exp_vld = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
